// File: rtl/mmio_bus_master.sv
// Initiator for the CS_N/RD_N/WR_N peripheral bus: turns single CPU load/store requests into
// timed strobe cycles with one response each, and synchronizes the peripheral interrupt.
module mmio_bus_master #(
  parameter logic [19:0] IO_BASE    = 20'hFFFF0,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        CS_N,
  output logic        RD_N,
  output logic        WR_N,
  output logic [11:0] Addr,
  output logic [31:0] WData,
  input  logic [31:0] RData,
  input  logic        Intr_N,
  output logic        irq
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StResp
  } state_e;

  // Counter reload values: each state lasts (load + 1) cycles.
  localparam int unsigned SetupM1  = (SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0;
  localparam int unsigned StrobeM1 = (STROBE_CYC > 0) ? STROBE_CYC - 1 : 0;
  localparam int unsigned HoldM1   = (HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0;
  localparam logic [3:0]  SetupLoad  = SetupM1[3:0];
  localparam logic [3:0]  StrobeLoad = StrobeM1[3:0];
  localparam logic [3:0]  HoldLoad   = HoldM1[3:0];
  localparam bit          HasSetup   = (SETUP_CYC != 0);
  localparam bit          HasHold    = (HOLD_CYC != 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        sync1_q, sync2_q;

  logic accept;
  logic legal;
  logic bus_active;

  assign accept = req_valid & req_ready_q;
  assign legal  = (req_addr[31:12] == IO_BASE) && (req_addr[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d      = req_addr[11:0];
          wdata_d     = req_wdata;
          we_d        = req_we;
          rsp_rdata_d = '0;
          if (!legal) begin
            // Rejected requests never touch the bus; err is only ever high alongside rsp_valid.
            state_d   = StResp;
            rsp_err_d = 1'b1;
          end else if (HasSetup) begin
            state_d = StSetup;
            cnt_d   = SetupLoad;
          end else begin
            state_d = StStrobe;
            cnt_d   = StrobeLoad;
          end
        end
      end

      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StStrobe: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rsp_rdata_d = RData;
          end
          if (HasHold) begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end else begin
            state_d = StResp;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus and handshake outputs are registered from the next state, so each appears in the
  // same cycle as the state it belongs to.
  always_comb begin
    bus_active  = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    cs_n_d      = ~bus_active;
    rd_n_d      = ~((state_d == StStrobe) && !we_d);
    wr_n_d      = ~((state_d == StStrobe) && we_d);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      sync1_q     <= Intr_N;
      sync2_q     <= sync1_q;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign CS_N      = cs_n_q;
  assign RD_N      = rd_n_q;
  assign WR_N      = wr_n_q;
  assign Addr      = addr_q;
  assign WData     = wdata_q;
  assign irq       = ~sync2_q;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Directed bench for mmio_bus_master: default timing instance plus a SETUP=0/STROBE=1/HOLD=0
// instance, with a small combinational peripheral read model on each.
module tb_mmio_bus_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        sel;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        intr_n;

  logic        ready1, rv1, err1, cs1, rd1, wr1, irq1;
  logic [31:0] rdata1, wd1, pdata1;
  logic [11:0] addr1;
  logic        ready2, rv2, err2, cs2, rd2, wr2, irq2;
  logic [31:0] rdata2, wd2, pdata2;
  logic [11:0] addr2;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] periph(input logic [11:0] a);
    return (a == 12'h000) ? 32'h2 : ({20'h0, a} ^ 32'hA5A50000);
  endfunction

  assign pdata1 = periph(addr1);
  assign pdata2 = periph(addr2);

  mmio_bus_master dut (
    .CLOCK_50(clk), .reset(rst_n), .req_valid(req_valid & ~sel), .req_ready(ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1),
    .rsp_rdata(rdata1), .rsp_err(err1), .CS_N(cs1), .RD_N(rd1), .WR_N(wr1), .Addr(addr1),
    .WData(wd1), .RData(pdata1), .Intr_N(intr_n), .irq(irq1)
  );

  mmio_bus_master #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut2 (
    .CLOCK_50(clk), .reset(rst_n), .req_valid(req_valid & sel), .req_ready(ready2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2),
    .rsp_rdata(rdata2), .rsp_err(err2), .CS_N(cs2), .RD_N(rd2), .WR_N(wr2), .Addr(addr2),
    .WData(wd2), .RData(pdata2), .Intr_N(intr_n), .irq(irq2)
  );

  logic        m_ready, m_rv, m_err, m_cs, m_rd, m_wr;
  logic [31:0] m_rdata, m_wd;
  logic [11:0] m_addr;
  assign m_ready = sel ? ready2 : ready1;
  assign m_rv    = sel ? rv2 : rv1;
  assign m_err   = sel ? err2 : err1;
  assign m_cs    = sel ? cs2 : cs1;
  assign m_rd    = sel ? rd2 : rd1;
  assign m_wr    = sel ? wr2 : wr1;
  assign m_rdata = sel ? rdata2 : rdata1;
  assign m_wd    = sel ? wd2 : wd1;
  assign m_addr  = sel ? addr2 : addr1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the last run_txn
  int          r_rsp_cyc, r_rsp_cnt, r_cs, r_rd, r_wr;
  logic [31:0] r_rdata;
  logic        r_err, r_unstable, r_both;

  task automatic run_txn(input logic s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int w = 0;
    sel = s; req_we = we; req_addr = addr; req_wdata = wdata;
    r_rsp_cyc = -1; r_rsp_cnt = 0; r_cs = 0; r_rd = 0; r_wr = 0;
    r_rdata = 32'hDEAD_BEEF; r_err = 1'bx; r_unstable = 1'b0; r_both = 1'b0;
    req_valid = 1'b1;
    while (m_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (m_cs === 1'b0) begin
        r_cs++;
        if (m_addr !== addr[11:0] || m_wd !== wdata) r_unstable = 1'b1;
      end
      if (m_rd === 1'b0) r_rd++;
      if (m_wr === 1'b0) r_wr++;
      if (m_rd === 1'b0 && m_wr === 1'b0) r_both = 1'b1;
      if (m_rv === 1'b1) begin
        r_rsp_cnt++;
        if (r_rsp_cyc < 0) begin
          r_rsp_cyc = k; r_rdata = m_rdata; r_err = m_err;
        end
      end
      if (r_rsp_cyc >= 0 && k == r_rsp_cyc + 1) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = 1'b0; sel = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    intr_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready1, rv1, err1, cs1, rd1, wr1, irq1} !== 7'b0001110) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0001110", {ready1, rv1, err1, cs1, rd1, wr1, irq1});
    end
    checks++;
    if (addr1 !== 12'h0 || wd1 !== 32'h0 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got addr %h wdata %h rdata %h expected zeros", addr1, wd1, rdata1);
    end
    #9 rst_n = 1'b1;
    #1;
    checks++;
    if (ready1 !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 0", ready1);
    end
    tick();
    checks++;
    if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %b%b expected 11", ready1, ready2);
    end
  endtask

  task automatic test_read();
    run_txn(1'b0, 1'b0, 32'hFFFF_0000, 32'h0);
    checks++;
    if (r_rsp_cyc !== 5 || r_rsp_cnt !== 1 || r_rdata !== 32'h2 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL read0_rsp: got cyc %0d cnt %0d rdata %h err %b expected 5 1 00000002 0",
               r_rsp_cyc, r_rsp_cnt, r_rdata, r_err);
    end
    checks++;
    if (r_cs !== 4 || r_rd !== 2 || r_wr !== 0 || r_unstable !== 1'b0) begin
      errors++;
      $display("FAIL read0_bus: got cs %0d rd %0d wr %0d unstable %b expected 4 2 0 0",
               r_cs, r_rd, r_wr, r_unstable);
    end
    run_txn(1'b0, 1'b0, 32'hFFFF_00FC, 32'h0);
    checks++;
    if (r_rsp_cyc !== 5 || r_rdata !== 32'hA5A5_00FC || r_rd !== 2) begin
      errors++;
      $display("FAIL read_fc: got cyc %0d rdata %h rd %0d expected 5 a5a500fc 2",
               r_rsp_cyc, r_rdata, r_rd);
    end
  endtask

  task automatic test_write();
    run_txn(1'b0, 1'b1, 32'hFFFF_0010, 32'h40);
    checks++;
    if (r_rsp_cyc !== 5 || r_rsp_cnt !== 1 || r_rdata !== 32'h0 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: got cyc %0d cnt %0d rdata %h err %b expected 5 1 0 0",
               r_rsp_cyc, r_rsp_cnt, r_rdata, r_err);
    end
    checks++;
    if (r_cs !== 4 || r_wr !== 2 || r_rd !== 0 || r_unstable !== 1'b0 || r_both !== 1'b0) begin
      errors++;
      $display("FAIL write_bus: got cs %0d wr %0d rd %0d unstable %b both %b expected 4 2 0 0 0",
               r_cs, r_wr, r_rd, r_unstable, r_both);
    end
    checks++;
    if (addr1 !== 12'h010 || wd1 !== 32'h40) begin
      errors++;
      $display("FAIL write_hold_vals: got addr %h wdata %h expected 010 00000040", addr1, wd1);
    end
  endtask

  task automatic test_errors();
    logic [31:0] bad [2];
    bad[0] = 32'h0000_1000;
    bad[1] = 32'hFFFF_0002;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, 1'b0, bad[i], 32'h0);
      checks++;
      if (r_rsp_cyc !== 1 || r_rsp_cnt !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
        errors++;
        $display("FAIL err_rsp[%0d]: got cyc %0d cnt %0d err %b rdata %h expected 1 1 1 0",
                 i, r_rsp_cyc, r_rsp_cnt, r_err, r_rdata);
      end
      checks++;
      if (r_cs !== 0 || r_rd !== 0 || r_wr !== 0) begin
        errors++;
        $display("FAIL err_bus[%0d]: got cs %0d rd %0d wr %0d expected 0 0 0", i, r_cs, r_rd, r_wr);
      end
    end
    checks++;
    if (err1 !== 1'b0) begin
      errors++;
      $display("FAIL err_clears: got %b expected 0", err1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cs_low;
    int          acc2, rsp1, rsp2, w;
    logic [31:0] rd_a, rd_b;
    logic        err_b;
    cs_low = '0; acc2 = -1; rsp1 = -1; rsp2 = -1; w = 0;
    rd_a = 32'hX; rd_b = 32'hX; err_b = 1'bx;
    sel = 1'b0; req_we = 1'b0; req_addr = 32'hFFFF_0000; req_wdata = 32'h0;
    req_valid = 1'b1;
    while (ready1 !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    tick();
    req_we = 1'b1; req_addr = 32'hFFFF_0010; req_wdata = 32'h40;
    for (int k = 1; k <= 14; k++) begin
      cs_low[k] = ~cs1;
      if (rv1 === 1'b1) begin
        if (rsp1 < 0) begin
          rsp1 = k; rd_a = rdata1;
        end else if (rsp2 < 0) begin
          rsp2 = k; rd_b = rdata1; err_b = err1;
        end
      end
      if (acc2 < 0 && ready1 === 1'b1 && req_valid) acc2 = k;
      tick();
      if (acc2 == k) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++;
    if (acc2 !== 6 || rsp1 !== 5 || rsp2 !== 11) begin
      errors++;
      $display("FAIL b2b_timing: got acc2 %0d rsp1 %0d rsp2 %0d expected 6 5 11", acc2, rsp1, rsp2);
    end
    checks++;
    if (cs_low !== 16'h079E) begin
      errors++;
      $display("FAIL b2b_cs_trace: got %h expected 079e", cs_low);
    end
    checks++;
    if (rd_a !== 32'h2 || rd_b !== 32'h0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_data: got %h %h err %b expected 00000002 00000000 0", rd_a, rd_b, err_b);
    end
  endtask

  task automatic test_reset_in_strobe();
    int w = 0;
    int seen = 0;
    sel = 1'b0; req_we = 1'b0; req_addr = 32'hFFFF_0000; req_wdata = 32'h0;
    req_valid = 1'b1;
    while (ready1 !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (rd1 !== 1'b0 || cs1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_strobe: got rd %b cs %b expected 0 0", rd1, cs1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cs1, rd1, wr1, ready1, rv1} !== 5'b11100) begin
      errors++;
      $display("FAIL rst_async: got %b expected 11100", {cs1, rd1, wr1, ready1, rv1});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_rise: got %b expected 1", ready1);
    end
    for (int k = 0; k < 6; k++) begin
      if (rv1 === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_rsp: got %0d pulses expected 0", seen);
    end
    run_txn(1'b0, 1'b0, 32'hFFFF_0000, 32'h0);
    checks++;
    if (r_rsp_cyc !== 5 || r_rdata !== 32'h2 || r_rd !== 2 || r_cs !== 4) begin
      errors++;
      $display("FAIL rst_recover: got cyc %0d rdata %h rd %0d cs %0d expected 5 2 2 4",
               r_rsp_cyc, r_rdata, r_rd, r_cs);
    end
  endtask

  task automatic test_short_params();
    run_txn(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
    checks++;
    if (r_rsp_cyc !== 2 || r_cs !== 1 || r_rd !== 1 || r_wr !== 0 || r_rdata !== 32'hA5A5_0004) begin
      errors++;
      $display("FAIL short_read: got cyc %0d cs %0d rd %0d wr %0d rdata %h expected 2 1 1 0 a5a50004",
               r_rsp_cyc, r_cs, r_rd, r_wr, r_rdata);
    end
    run_txn(1'b1, 1'b1, 32'hFFFF_0020, 32'h1234);
    checks++;
    if (r_rsp_cyc !== 2 || r_cs !== 1 || r_wr !== 1 || r_rd !== 0 || r_rdata !== 32'h0) begin
      errors++;
      $display("FAIL short_write: got cyc %0d cs %0d wr %0d rd %0d rdata %h expected 2 1 1 0 0",
               r_rsp_cyc, r_cs, r_wr, r_rd, r_rdata);
    end
    sel = 1'b0;
  endtask

  task automatic test_irq();
    intr_n = 1'b0;
    tick();
    checks++;
    if (irq1 !== 1'b0 || irq2 !== 1'b0) begin
      errors++;
      $display("FAIL irq_edge1: got %b%b expected 00", irq1, irq2);
    end
    tick();
    checks++;
    if (irq1 !== 1'b1 || irq2 !== 1'b1) begin
      errors++;
      $display("FAIL irq_edge2: got %b%b expected 11", irq1, irq2);
    end
    intr_n = 1'b1;
    tick();
    checks++;
    if (irq1 !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold: got %b expected 1", irq1);
    end
    tick();
    checks++;
    if (irq1 !== 1'b0 || irq2 !== 1'b0) begin
      errors++;
      $display("FAIL irq_level: got %b%b expected 00", irq1, irq2);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_errors();
    test_back_to_back();
    test_reset_in_strobe();
    test_short_params();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
